overlay_streamer: RTL and testbench
===================================

# overlay_streamer

Terminal consumer of the Hough pipeline's Req/Ack stage interface. On each upstream request it captures one frame matrix plus its single-bit overlay, holds the upstream stage stalled, and serialises the composited frame one pixel per accepted beat in raster order to a display/link writer over a valid/ready stream. Sits directly downstream of the Hough transform stage; its `AckIn` output drives that stage's `AckOut` input.

## Interface
- `IMAGE_BITS`, 8: bits per pixel.
- `MATRIX_N`, 120: pixels across (columns).
- `MATRIX_M`, 120: pixels down (rows).
- `OVERLAY_COLOUR`, {IMAGE_BITS{1'b1}}: pixel value substituted where the overlay bit is set.
- `OVERLAY_FLAT_WIDE`, MATRIX_N*MATRIX_M; `FLAT_WIDE`, IMAGE_BITS*MATRIX_N*MATRIX_M: derived.

Ports:
- `Clk`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-high.
- `ImgMatIn`  in  FLAT_WIDE  flat image; pixel (row i, col j) at bits [(i*MATRIX_N+j)*IMAGE_BITS +: IMAGE_BITS].
- `OverlayMatIn`  in  OVERLAY_FLAT_WIDE  overlay; bit (i*MATRIX_N+j).
- `ReqIn`  in  1  upstream request; data registered upstream on the edge where ReqIn is high.
- `AckIn`  out  1  busy/stall to upstream; high holds the upstream stage.
- `PixOut`  out  IMAGE_BITS  composited pixel.
- `PixValid`  out  1  PixOut valid.
- `PixReady`  in  1  sink accepts when PixValid & PixReady.
- `PixLineEnd`  out  1  current pixel is column MATRIX_N-1.
- `PixFrameEnd`  out  1  current pixel is the last of the frame.
- `FrameCount`  out  8  frames fully streamed, wraps 255→0.

## Operation
- States: IDLE, CAPTURE, STREAM (encoding in package).
- IDLE: AckIn=0, PixValid=0. ReqIn sampled high → CAPTURE.
- CAPTURE (exactly 1 cycle): AckIn=1; on exit edge, `ImgMatIn` and `OverlayMatIn` are latched into the frame buffer; row/col counters cleared → STREAM.
- STREAM: AckIn=1, PixValid=1. PixOut = OVERLAY_COLOUR if overlay bit (row,col) set, else image pixel (row,col). On accept: col+1; at col=MATRIX_N-1, col→0, row+1. Accept of pixel (MATRIX_M-1, MATRIX_N-1) → IDLE, FrameCount+1.
- No accept (PixReady=0): counters, PixOut, PixValid held stable.
- ReqIn ignored in CAPTURE and STREAM (upstream is stalled by AckIn). ReqIn high on the edge of the final accept is ignored; re-sampled the following edge from IDLE.
- PixOut, PixLineEnd, PixFrameEnd forced 0 whenever PixValid=0.
- Counters: col width $clog2(MATRIX_N), row width $clog2(MATRIX_M); never exceed N-1/M-1.
- Reset (any time, incl. mid-frame): state→IDLE, counters 0, FrameCount 0, buffer 0; all outputs 0. Partial frame is discarded and not counted.

## Timing
- AckIn, PixValid decoded from registered state, no combinational path from ReqIn or PixReady to any output.
- ReqIn sampled high at edge k → AckIn=1 from k, capture at edge k+1, first PixValid cycle after k+1.
- PixReady tied high: one pixel per cycle, AckIn high for 1+MATRIX_N*MATRIX_M cycles, low the cycle after final accept.
- Back-to-back: with ReqIn continuously high, next CAPTURE begins one IDLE cycle after the final accept.

## Structure
- Package `hough_pkg`: state enum type, default OVERLAY_COLOUR constant, pixel index helper function (row,col → flat offset).
- Sub-module `raster_counter` (params MATRIX_N, MATRIX_M; inputs clear, advance; outputs row, col, line_end, frame_end); the FSM, buffer and composite mux stay top-level.

## Test plan
Parameters for bench: MATRIX_N=4, MATRIX_M=3, IMAGE_BITS=8.
- Reset then idle: all outputs 0, AckIn=0; ReqIn low for 20 cycles → no PixValid.
- Pixel k = k (0..11), overlay 0, PixReady=1, one ReqIn pulse → PixOut 0..11 on consecutive cycles, PixLineEnd on 3,7,11, PixFrameEnd on 11, FrameCount=1, AckIn high 13 cycles.
- Same image, overlay bits 0 and 5 set → PixOut sequence 0xFF,1,2,3,4,0xFF,6,...,11.
- PixReady toggled 1,0,0,1 pattern → PixOut/flags stable while stalled, no pixel dropped or repeated, 12 accepts total.
- ImgMatIn changed during STREAM and ReqIn held high → current frame unaffected; second frame follows after one IDLE cycle; FrameCount=2.
- Reset asserted after 5 accepts → outputs 0 asynchronously, FrameCount=0; next ReqIn streams full 12-pixel frame from pixel 0.

Source files
------------

// File: rtl/hough_pkg.sv
// -----------------------------------------------------------------------------
// hough_pkg
// Shared definitions for the Hough pipeline display back-end:
//   state_t                 - overlay_streamer FSM state encoding
//   DEFAULT_OVERLAY_COLOUR  - default substitute value for 8-bit pixels
//   pix_index()             - (row, col) -> flat pixel offset in raster order
// -----------------------------------------------------------------------------
package hough_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_STREAM  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_IMAGE_BITS = 8;
    localparam logic [DEFAULT_IMAGE_BITS-1:0] DEFAULT_OVERLAY_COLOUR = '1;

    // Raster-order flat offset of pixel (row, col) in a frame n columns wide.
    function automatic int unsigned pix_index(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned n);
        return row * n + col;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Row/column position counter walking a MATRIX_M x MATRIX_N frame in raster
// order. Wraps to (0,0) after the last pixel.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clear_i       synchronous return to (0,0); wins over advance_i
//   advance_i     step to the next pixel
//   row_o, col_o  current position
//   line_end_o    col_o is the last column
//   frame_end_o   position is the last pixel of the frame
// -----------------------------------------------------------------------------
module raster_counter #(
    parameter int MATRIX_N = 120,
    parameter int MATRIX_M = 120,
    localparam int COL_W = (MATRIX_N > 1) ? $clog2(MATRIX_N) : 1,
    localparam int ROW_W = (MATRIX_M > 1) ? $clog2(MATRIX_M) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             line_end_o,
    output logic             frame_end_o
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             last_col, last_row;

    assign last_col = (col_q == COL_W'(MATRIX_N - 1));
    assign last_row = (row_q == ROW_W'(MATRIX_M - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o       = row_q;
    assign col_o       = col_q;
    assign line_end_o  = last_col;
    assign frame_end_o = last_col & last_row;

endmodule

// File: rtl/overlay_streamer.sv
// -----------------------------------------------------------------------------
// overlay_streamer
// Terminal Req/Ack consumer of the Hough pipeline. Captures one frame plus its
// 1-bit overlay on request, stalls upstream via AckIn, and streams the
// composited frame one pixel per accepted beat in raster order.
//   Clk, Reset      clock, asynchronous active-high reset
//   ImgMatIn        flat image, pixel (i,j) at [(i*N+j)*IMAGE_BITS +: IMAGE_BITS]
//   OverlayMatIn    flat overlay, bit (i*N+j)
//   ReqIn           upstream request (sampled in IDLE only)
//   AckIn           busy/stall to upstream (high in CAPTURE and STREAM)
//   PixOut          composited pixel (0 when PixValid is low)
//   PixValid        stream valid; PixReady accepts; beat = PixValid & PixReady
//   PixLineEnd      current pixel is the last column
//   PixFrameEnd     current pixel is the last of the frame
//   FrameCount      completed frames, wraps at 8 bits
//   DbgState        FSM state for observation
// Stream handshake: a beat transfers on a rising edge where PixValid and
// PixReady are both high; while PixReady is low, PixValid, PixOut and the flags
// hold. All outputs decode from registers only.
// -----------------------------------------------------------------------------
module overlay_streamer
    import hough_pkg::*;
#(
    parameter int IMAGE_BITS = 8,
    parameter int MATRIX_N   = 120,
    parameter int MATRIX_M   = 120,
    parameter logic [IMAGE_BITS-1:0] OVERLAY_COLOUR = {IMAGE_BITS{1'b1}},
    localparam int OVERLAY_FLAT_WIDE = MATRIX_N * MATRIX_M,
    localparam int FLAT_WIDE         = IMAGE_BITS * MATRIX_N * MATRIX_M
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [FLAT_WIDE-1:0]         ImgMatIn,
    input  logic [OVERLAY_FLAT_WIDE-1:0] OverlayMatIn,
    input  logic                         ReqIn,
    output logic                         AckIn,
    output logic [IMAGE_BITS-1:0]        PixOut,
    output logic                         PixValid,
    input  logic                         PixReady,
    output logic                         PixLineEnd,
    output logic                         PixFrameEnd,
    output logic [7:0]                   FrameCount,
    output state_t                       DbgState
);

    localparam int COL_W = (MATRIX_N > 1) ? $clog2(MATRIX_N) : 1;
    localparam int ROW_W = (MATRIX_M > 1) ? $clog2(MATRIX_M) : 1;
    localparam int IDX_W = (OVERLAY_FLAT_WIDE > 1) ? $clog2(OVERLAY_FLAT_WIDE) : 1;

    state_t state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Frame buffer kept in the same bit layout as ImgMatIn so capture is a copy.
    logic [OVERLAY_FLAT_WIDE-1:0][IMAGE_BITS-1:0] img_q;
    logic [OVERLAY_FLAT_WIDE-1:0]                 ovl_q;

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             line_end, frame_end;
    logic             capture, accept;
    logic [IDX_W-1:0] pix_idx;

    assign capture = (state_q == ST_CAPTURE);
    assign accept  = (state_q == ST_STREAM) & PixReady;

    raster_counter #(
        .MATRIX_N (MATRIX_N),
        .MATRIX_M (MATRIX_M)
    ) u_raster (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .clear_i     (capture),
        .advance_i   (accept),
        .row_o       (row),
        .col_o       (col),
        .line_end_o  (line_end),
        .frame_end_o (frame_end)
    );

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            ST_IDLE:    if (ReqIn) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_STREAM;
            ST_STREAM: begin
                if (accept && frame_end) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Upstream registers its data on the ReqIn edge, so it is stable through
    // CAPTURE and taken on the CAPTURE exit edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            img_q <= '0;
            ovl_q <= '0;
        end else if (capture) begin
            img_q <= ImgMatIn;
            ovl_q <= OverlayMatIn;
        end
    end

    assign pix_idx = IDX_W'(pix_index(32'(row), 32'(col), MATRIX_N));

    assign AckIn       = (state_q != ST_IDLE);
    assign PixValid    = (state_q == ST_STREAM);
    assign PixOut      = !PixValid      ? '0 :
                         ovl_q[pix_idx] ? OVERLAY_COLOUR : img_q[pix_idx];
    assign PixLineEnd  = PixValid & line_end;
    assign PixFrameEnd = PixValid & frame_end;
    assign FrameCount  = frame_cnt_q;
    assign DbgState    = state_q;

endmodule

// File: tb/tb_overlay_streamer.sv
// -----------------------------------------------------------------------------
// tb_overlay_streamer
// Scoreboard bench for overlay_streamer at N=4, M=3, 8-bit pixels. Stimulus
// pushes expected beats {frame_end, line_end, pixel} into exp_q; a monitor
// pops and compares on every accepted beat.
// -----------------------------------------------------------------------------
module tb_overlay_streamer;

  localparam int B  = 8;
  localparam int N  = 4;
  localparam int M  = 3;
  localparam int NM = N * M;
  localparam int W  = B + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [B*NM-1:0]   img_in;
  logic [NM-1:0]     ovl_in;
  logic              req_in;
  logic              ack;
  logic [B-1:0]      pix_out;
  logic              pix_valid;
  logic              pix_ready;
  logic              line_end;
  logic              frame_end;
  logic [7:0]        frame_count;
  hough_pkg::state_t dbg_state;

  overlay_streamer #(
    .IMAGE_BITS (B),
    .MATRIX_N   (N),
    .MATRIX_M   (M)
  ) dut (
    .Clk          (clk),
    .Reset        (rst),
    .ImgMatIn     (img_in),
    .OverlayMatIn (ovl_in),
    .ReqIn        (req_in),
    .AckIn        (ack),
    .PixOut       (pix_out),
    .PixValid     (pix_valid),
    .PixReady     (pix_ready),
    .PixLineEnd   (line_end),
    .PixFrameEnd  (frame_end),
    .FrameCount   (frame_count),
    .DbgState     (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int exp_frames = 0;
  int ready_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: composite each pixel from the frame rules and queue it.
  task automatic push_frame(input logic [B*NM-1:0] img, input logic [NM-1:0] ovl);
    logic [B-1:0] p;
    for (int k = 0; k < NM; k++) begin
      p = ovl[k] ? 8'hFF : img[k*B +: B];
      exp_q.push_back({(k == NM - 1), ((k % N) == N - 1), p});
    end
    exp_frames++;
  endtask

  task automatic rand_frame(output logic [B*NM-1:0] img, output logic [NM-1:0] ovl);
    for (int k = 0; k < NM; k++) img[k*B +: B] = B'($urandom_range(0, 255));
    ovl = NM'($urandom);
  endtask

  // ---------------- ready driver ----------------
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = pat[cyc % 4];
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
    end
  end

  // ---------------- monitor ----------------
  logic         held_v = 1'b0;
  logic [W-1:0] held_val;
  always @(negedge clk) begin
    logic [W-1:0] cur;
    logic [W-1:0] e;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      cur = {frame_end, line_end, pix_out};
      if (held_v) check("stall_hold", {pix_valid, cur}, {1'b1, held_val});
      if (pix_valid) begin
        if (pix_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got 0x%0h expected none", cur);
          end else begin
            e = exp_q.pop_front();
            check("beat", cur, e);
          end
          acc_cnt++;
          held_v = 1'b0;
        end else begin
          held_v   = 1'b1;
          held_val = cur;
        end
      end else begin
        held_v = 1'b0;
        check("invalid_zero", cur, '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_req();
    @(posedge clk);
    #1 req_in = 1'b1;
    @(posedge clk);
    #1 req_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !ack) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d beats left expected 0", name, exp_q.size());
    end
    check({name, "_frame_count"}, 32'(frame_count), 32'(exp_frames));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [B*NM-1:0] img_a, img_b;
    logic [NM-1:0]   ovl_a, ovl_b;
    int base, ack_cycles, gap;
    bit seen, ok;

    rst = 1'b1; req_in = 1'b0; img_in = '0; ovl_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_pix", {22'd0, frame_end, line_end, pix_out}, 0);
    check("rst_frame_count", 32'(frame_count), 0);
    rst = 1'b0;

    // Idle: no request, nothing streams.
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (pix_valid || ack) seen = 1;
    end
    check("idle20_activity", 32'(seen), 0);

    // Ramp image, no overlay, always ready; timing of AckIn and first beat.
    for (int k = 0; k < NM; k++) img_a[k*B +: B] = B'(k);
    ovl_a = '0;
    img_in = img_a; ovl_in = ovl_a;
    push_frame(img_a, ovl_a);
    pulse_req();
    ack_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) check("capture_no_valid", 32'(pix_valid), 0);
      if (i == 1) check("first_valid", 32'(pix_valid), 1);
      if (!ack) break;
      ack_cycles++;
    end
    check("ack_cycles", 32'(ack_cycles), 32'(1 + NM));
    wait_drain("ramp");

    // Overlay bits 0 and 5.
    ovl_a = 12'b0000_0010_0001;
    ovl_in = ovl_a;
    push_frame(img_a, ovl_a);
    pulse_req();
    wait_drain("overlay");

    // Stalling sink 1,0,0,1.
    ready_mode = 1;
    rand_frame(img_a, ovl_a);
    img_in = img_a; ovl_in = ovl_a;
    base = acc_cnt;
    push_frame(img_a, ovl_a);
    pulse_req();
    wait_drain("stall");
    check("stall_accepts", 32'(acc_cnt - base), 32'(NM));

    // Back-to-back with ReqIn held; image changes mid-stream.
    ready_mode = 0;
    rand_frame(img_a, ovl_a);
    rand_frame(img_b, ovl_b);
    img_in = img_a; ovl_in = ovl_a;
    push_frame(img_a, ovl_a);
    @(posedge clk);
    #1 req_in = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pix_valid) begin ok = 1; break; end
    end
    check("b2b_first_stream", 32'(ok), 1);
    @(posedge clk);
    #1 img_in = img_b; ovl_in = ovl_b;
    push_frame(img_b, ovl_b);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!ack) begin ok = 1; break; end
    end
    gap = 0;
    for (int i = 0; i < 20 && ok && !ack; i++) begin
      gap++;
      @(negedge clk);
    end
    check("b2b_idle_gap", 32'(gap), 1);
    @(posedge clk);
    #1 req_in = 1'b0;
    wait_drain("b2b");

    // Reset after 5 accepts.
    rand_frame(img_a, ovl_a);
    img_in = img_a; ovl_in = ovl_a;
    base = acc_cnt;
    push_frame(img_a, ovl_a);
    pulse_req();
    for (int i = 0; i < 100 && acc_cnt < base + 5; i++) @(negedge clk);
    check("pre_reset_accepts", 32'(acc_cnt - base), 5);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_ack", 32'(ack), 0);
    check("mid_rst_valid", 32'(pix_valid), 0);
    check("mid_rst_pix", {22'd0, frame_end, line_end, pix_out}, 0);
    check("mid_rst_frame_count", 32'(frame_count), 0);
    exp_q.delete();
    exp_frames = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rand_frame(img_a, ovl_a);
    img_in = img_a; ovl_in = ovl_a;
    base = acc_cnt;
    push_frame(img_a, ovl_a);
    pulse_req();
    wait_drain("post_reset");
    check("post_reset_accepts", 32'(acc_cnt - base), 32'(NM));

    // Random frames with random backpressure.
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      rand_frame(img_a, ovl_a);
      img_in = img_a; ovl_in = ovl_a;
      push_frame(img_a, ovl_a);
      pulse_req();
      wait_drain("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
